// File: rtl/msg_pkg.sv
// Shared sizes and edit-FSM state type for the rotating-message loader.
package msg_pkg;

    localparam int MSG_DEPTH = 16;
    localparam int DIGIT_W   = 4;
    localparam int ADDR_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_DONE = 2'd2
    } edit_state_t;

    // Power-on content of an entry: the fixed 0..F pattern
    function automatic logic [DIGIT_W-1:0] default_digit(input int idx);
        return DIGIT_W'(idx);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, stability-window debounce,
// and a single-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk_out,
    input  logic reset_use,
    input  logic btn_raw,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk_out domain
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has held for the whole window; pulse on the 0->1 flip
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (sync_2 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
                pulse <= sync_2;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                pulse <= 1'b0;
            end
        end else begin
            cnt   <= '0;
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/message_loader.sv
// Writer side of the 16 x 4-bit rotating message: three debounced buttons drive
// an edit FSM that rewrites the message; the rotator reads it asynchronously.
module message_loader
    import msg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic               clk_out,
    input  logic               reset_use,
    input  logic               btn_edit,
    input  logic               btn_next,
    input  logic               btn_inc,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DIGIT_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  wr_ptr,
    output logic [DIGIT_W-1:0] digit_buf,
    output logic               edit_active,
    output logic               msg_updated
);

    logic edit_pulse;
    logic next_pulse;
    logic inc_pulse;

    edit_state_t        state;
    edit_state_t        state_next;
    logic [ADDR_W-1:0]  wr_ptr_next;
    logic [ADDR_W-1:0]  ptr_plus1;
    logic [DIGIT_W-1:0] digit_next;
    logic               wr_en;

    logic [DIGIT_W-1:0] message [MSG_DEPTH];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_edit (
        .clk_out(clk_out), .reset_use(reset_use), .btn_raw(btn_edit), .pulse(edit_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
        .clk_out(clk_out), .reset_use(reset_use), .btn_raw(btn_next), .pulse(next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_inc (
        .clk_out(clk_out), .reset_use(reset_use), .btn_raw(btn_inc), .pulse(inc_pulse)
    );

    assign ptr_plus1 = wr_ptr + ADDR_W'(1);
    assign rd_data   = message[rd_addr];

    // Edit decisions; edit outranks next, next outranks inc, losers are simply dropped
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        digit_next  = digit_buf;
        wr_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (edit_pulse) begin
                    state_next  = ST_EDIT;
                    wr_ptr_next = '0;
                    digit_next  = message[ADDR_W'(0)];
                end
            end
            ST_EDIT: begin
                if (edit_pulse) begin
                    wr_en      = 1'b1;
                    state_next = ST_DONE;
                end else if (next_pulse) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = ptr_plus1;
                    digit_next  = message[ptr_plus1];
                    if (wr_ptr == ADDR_W'(MSG_DEPTH - 1)) begin
                        state_next = ST_DONE;
                    end
                end else if (inc_pulse) begin
                    digit_next = digit_buf + DIGIT_W'(1);
                end
            end
            ST_DONE: begin
                state_next  = ST_IDLE;
                wr_ptr_next = '0;
            end
            default: begin
                state_next  = ST_IDLE;
                wr_ptr_next = '0;
            end
        endcase
    end

    // Control registers; status flags are registered alongside the state they describe
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            digit_buf   <= '0;
            edit_active <= 1'b0;
            msg_updated <= 1'b0;
        end else begin
            state       <= state_next;
            wr_ptr      <= wr_ptr_next;
            digit_buf   <= digit_next;
            edit_active <= (state_next == ST_EDIT);
            msg_updated <= (state_next == ST_DONE);
        end
    end

    // Message storage; reset restores the 0..F pattern, no read bypass on writes
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                message[i] <= default_digit(i);
            end
        end else if (wr_en) begin
            message[wr_ptr] <= digit_buf;
        end
    end

endmodule

// File: tb/tb_message_loader.sv
// Bench for message_loader with a short debounce window and an event-level reference model.
module tb_message_loader;

    localparam int DEB      = 4;
    localparam int PRESS_HI = 10;
    localparam int PRESS_LO = 10;

    logic       clk_out = 1'b0;
    logic       reset_use;
    logic       btn_edit;
    logic       btn_next;
    logic       btn_inc;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] wr_ptr;
    logic [3:0] digit_buf;
    logic       edit_active;
    logic       msg_updated;

    int checks    = 0;
    int fails     = 0;
    int upd_count = 0;

    logic [3:0] ref_msg [16];
    logic [3:0] ref_ptr;
    logic [3:0] ref_digit;
    logic       ref_edit;

    message_loader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clk_out(clk_out),
        .reset_use(reset_use),
        .btn_edit(btn_edit),
        .btn_next(btn_next),
        .btn_inc(btn_inc),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_ptr(wr_ptr),
        .digit_buf(digit_buf),
        .edit_active(edit_active),
        .msg_updated(msg_updated)
    );

    always #5 clk_out = ~clk_out;

    // Count every cycle in which the commit flag is seen high
    always @(negedge clk_out) begin
        if (msg_updated === 1'b1) upd_count++;
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_msg[i] = 4'(i);
        ref_ptr   = 4'd0;
        ref_digit = 4'd0;
        ref_edit  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_out);
        btn_edit  = 1'b0;
        btn_next  = 1'b0;
        btn_inc   = 1'b0;
        reset_use = 1'b1;
        repeat (2) @(negedge clk_out);
        reset_use = 1'b0;
        model_reset();
        @(negedge clk_out);
    endtask

    // One complete button action plus its effect on the reference message
    task automatic do_press(input bit e, input bit n, input bit i);
        @(negedge clk_out);
        btn_edit = e;
        btn_next = n;
        btn_inc  = i;
        repeat (PRESS_HI) @(negedge clk_out);
        btn_edit = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        repeat (PRESS_LO) @(negedge clk_out);
        if (!ref_edit) begin
            if (e) begin
                ref_edit  = 1'b1;
                ref_ptr   = 4'd0;
                ref_digit = ref_msg[0];
            end
        end else if (e) begin
            ref_msg[ref_ptr] = ref_digit;
            ref_edit = 1'b0;
            ref_ptr  = 4'd0;
        end else if (n) begin
            ref_msg[ref_ptr] = ref_digit;
            if (ref_ptr == 4'd15) begin
                ref_edit  = 1'b0;
                ref_ptr   = 4'd0;
                ref_digit = ref_msg[0];
            end else begin
                ref_ptr   = ref_ptr + 4'd1;
                ref_digit = ref_msg[ref_ptr];
            end
        end else if (i) begin
            ref_digit = ref_digit + 4'd1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checks++;
            if (rd_data !== 4'(i)) begin
                fails++;
                $display("[TB] FAIL reset_msg[%0d] got %h expected %h", i, rd_data, 4'(i));
            end
        end
        checks++;
        if (edit_active !== 1'b0 || msg_updated !== 1'b0 || wr_ptr !== 4'd0 || digit_buf !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got ea=%b mu=%b ptr=%h dig=%h expected 0 0 0 0",
                     edit_active, msg_updated, wr_ptr, digit_buf);
        end
    endtask

    task automatic test_glitch();
        int up0;
        do_reset();
        do_press(1'b1, 1'b0, 1'b0);
        checks++;
        if (edit_active !== 1'b1 || digit_buf !== ref_digit) begin
            fails++;
            $display("[TB] FAIL enter_edit got ea=%b dig=%h expected 1 %h", edit_active, digit_buf, ref_digit);
        end
        @(negedge clk_out);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk_out);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk_out);
        checks++;
        if (digit_buf !== ref_digit) begin
            fails++;
            $display("[TB] FAIL glitch_ignored got %h expected %h", digit_buf, ref_digit);
        end
        do_press(1'b0, 1'b0, 1'b1);
        checks++;
        if (digit_buf !== ref_digit) begin
            fails++;
            $display("[TB] FAIL single_inc got %h expected %h", digit_buf, ref_digit);
        end
        up0 = upd_count;
        do_press(1'b1, 1'b0, 1'b0);
        checks++;
        if (upd_count - up0 !== 1) begin
            fails++;
            $display("[TB] FAIL glitch_commit_pulses got %0d expected 1", upd_count - up0);
        end
    endtask

    task automatic test_basic_edit();
        int up0;
        do_reset();
        up0 = upd_count;
        do_press(1'b1, 1'b0, 1'b0);
        do_press(1'b0, 1'b0, 1'b1);
        do_press(1'b0, 1'b0, 1'b1);
        do_press(1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_ptr !== 4'd1 || digit_buf !== 4'd1 || edit_active !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_after_next got ptr=%h dig=%h ea=%b expected 1 1 1",
                     wr_ptr, digit_buf, edit_active);
        end
        do_press(1'b1, 1'b0, 1'b0);
        checks++;
        if (edit_active !== 1'b0 || wr_ptr !== 4'd0 || upd_count - up0 !== 1) begin
            fails++;
            $display("[TB] FAIL basic_commit got ea=%b ptr=%h pulses=%0d expected 0 0 1",
                     edit_active, wr_ptr, upd_count - up0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checks++;
            if (rd_data !== ((i == 0) ? 4'd2 : 4'(i))) begin
                fails++;
                $display("[TB] FAIL basic_msg[%0d] got %h expected %h", i, rd_data,
                         (i == 0) ? 4'd2 : 4'(i));
            end
        end
    endtask

    task automatic test_full_wrap();
        int up0;
        do_reset();
        up0 = upd_count;
        do_press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            repeat (5) do_press(1'b0, 1'b0, 1'b1);
            if (k == 15) begin
                checks++;
                if (wr_ptr !== 4'd15 || edit_active !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL wrap_last_ptr got ptr=%h ea=%b expected f 1", wr_ptr, edit_active);
                end
            end
            do_press(1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (edit_active !== 1'b0 || wr_ptr !== 4'd0 || upd_count - up0 !== 1) begin
            fails++;
            $display("[TB] FAIL wrap_done got ea=%b ptr=%h pulses=%0d expected 0 0 1",
                     edit_active, wr_ptr, upd_count - up0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checks++;
            if (rd_data !== 4'(i + 5)) begin
                fails++;
                $display("[TB] FAIL wrap_msg[%0d] got %h expected %h", i, rd_data, 4'(i + 5));
            end
        end
    endtask

    task automatic test_coincident();
        int up0;
        do_reset();
        do_press(1'b1, 1'b0, 1'b0);
        do_press(1'b0, 1'b1, 1'b1);
        checks++;
        if (wr_ptr !== ref_ptr || digit_buf !== ref_digit) begin
            fails++;
            $display("[TB] FAIL next_beats_inc got ptr=%h dig=%h expected %h %h",
                     wr_ptr, digit_buf, ref_ptr, ref_digit);
        end
        repeat (3) do_press(1'b0, 1'b0, 1'b1);
        up0 = upd_count;
        do_press(1'b1, 1'b1, 1'b0);
        checks++;
        if (edit_active !== 1'b0 || wr_ptr !== 4'd0 || upd_count - up0 !== 1) begin
            fails++;
            $display("[TB] FAIL edit_beats_next got ea=%b ptr=%h pulses=%0d expected 0 0 1",
                     edit_active, wr_ptr, upd_count - up0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checks++;
            if (rd_data !== ref_msg[i]) begin
                fails++;
                $display("[TB] FAIL coincident_msg[%0d] got %h expected %h", i, rd_data, ref_msg[i]);
            end
        end
    endtask

    task automatic test_random_sessions();
        int up0;
        int steps;
        int kind;
        up0 = upd_count;
        do_press(1'b0, 1'b1, 1'b0);
        do_press(1'b0, 1'b0, 1'b1);
        checks++;
        if (edit_active !== 1'b0 || wr_ptr !== 4'd0 || upd_count !== up0) begin
            fails++;
            $display("[TB] FAIL idle_ignores got ea=%b ptr=%h pulses=%0d expected 0 0 0",
                     edit_active, wr_ptr, upd_count - up0);
        end
        for (int s = 0; s < 3; s++) begin
            up0 = upd_count;
            do_press(1'b1, 1'b0, 1'b0);
            steps = $urandom_range(10, 3);
            for (int k = 0; k < steps; k++) begin
                kind = $urandom_range(2, 0);
                do_press(1'b0, kind == 0, kind != 0);
                checks++;
                if (wr_ptr !== ref_ptr || digit_buf !== ref_digit || edit_active !== ref_edit) begin
                    fails++;
                    $display("[TB] FAIL rand_step s%0d k%0d got ptr=%h dig=%h ea=%b expected %h %h %b",
                             s, k, wr_ptr, digit_buf, edit_active, ref_ptr, ref_digit, ref_edit);
                end
            end
            do_press(1'b1, 1'b0, 1'b0);
            checks++;
            if (edit_active !== 1'b0 || upd_count - up0 !== 1) begin
                fails++;
                $display("[TB] FAIL rand_commit s%0d got ea=%b pulses=%0d expected 0 1",
                         s, edit_active, upd_count - up0);
            end
            for (int i = 0; i < 16; i++) begin
                rd_addr = 4'($urandom_range(15, 0));
                #1;
                checks++;
                if (rd_data !== ref_msg[rd_addr]) begin
                    fails++;
                    $display("[TB] FAIL rand_msg[%0d] got %h expected %h", rd_addr, rd_data, ref_msg[rd_addr]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_edit();
        do_press(1'b1, 1'b0, 1'b0);
        repeat (7) do_press(1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_ptr !== 4'd7 || edit_active !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_edit_ptr got ptr=%h ea=%b expected 7 1", wr_ptr, edit_active);
        end
        @(negedge clk_out);
        reset_use = 1'b1;
        #1;
        checks++;
        if (edit_active !== 1'b0 || msg_updated !== 1'b0 || wr_ptr !== 4'd0 || digit_buf !== 4'd0) begin
            fails++;
            $display("[TB] FAIL async_reset_outputs got ea=%b mu=%b ptr=%h dig=%h expected 0 0 0 0",
                     edit_active, msg_updated, wr_ptr, digit_buf);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            checks++;
            if (rd_data !== 4'(i)) begin
                fails++;
                $display("[TB] FAIL async_reset_msg[%0d] got %h expected %h", i, rd_data, 4'(i));
            end
        end
        @(negedge clk_out);
        reset_use = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_out);
        checks++;
        if (edit_active !== 1'b0 || wr_ptr !== 4'd0) begin
            fails++;
            $display("[TB] FAIL post_reset_idle got ea=%b ptr=%h expected 0 0", edit_active, wr_ptr);
        end
    endtask

    initial begin
        reset_use = 1'b1;
        btn_edit  = 1'b0;
        btn_next  = 1'b0;
        btn_inc   = 1'b0;
        rd_addr   = 4'd0;
        model_reset();
        test_reset();
        test_glitch();
        test_basic_edit();
        test_full_wrap();
        test_coincident();
        test_random_sessions();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
